// File: rtl/ee457_p3_hazard_ctrl_if.sv
// rtl/ee457_p3_hazard_ctrl_if.sv - ID-side request and hazard/forward response bundle
interface ee457_p3_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [3:0]       id_opcode;
    logic [3:0]       id_rd;
    logic [3:0]       id_rs;
    logic             stall;
    logic             pc_we;
    logic             ifid_we;
    logic             ex1_bubble;
    logic [1:0]       ex1_fwd_sel;
    logic             wb_wen;
    logic [3:0]       wb_rd;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] fwd_cnt;

    modport master (
        output id_valid, id_opcode, id_rd, id_rs,
        input  stall, pc_we, ifid_we, ex1_bubble, ex1_fwd_sel,
               wb_wen, wb_rd, stall_cnt, fwd_cnt
    );

    modport slave (
        input  id_valid, id_opcode, id_rd, id_rs,
        output stall, pc_we, ifid_we, ex1_bubble, ex1_fwd_sel,
               wb_wen, wb_rd, stall_cnt, fwd_cnt
    );
endinterface

// File: rtl/ee457_p3_hazard_ctrl.sv
// rtl/ee457_p3_hazard_ctrl.sv - P3 pipeline load-use stall, bubble and EX1 forwarding control
module ee457_p3_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rstb,
    ee457_p3_hazard_ctrl_if.slave bus
);
    localparam logic [3:0] OP_ADD1 = 4'b0001;
    localparam logic [3:0] OP_ADD4 = 4'b0010;
    localparam logic [3:0] OP_SUB3 = 4'b0100;
    localparam logic [3:0] OP_MOV  = 4'b1000;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX2 = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Only the EX1 slot needs the late flag: by EX2 every result is ready.
    typedef struct packed {
        logic       writer;
        logic       late;
        logic [3:0] rd;
    } ex1_entry_t;

    typedef struct packed {
        logic       writer;
        logic [3:0] rd;
    } dst_entry_t;

    ex1_entry_t       sb_ex1;
    dst_entry_t       sb_ex2;
    dst_entry_t       sb_wb;
    ex1_entry_t       id_entry;
    ex1_entry_t       next_ex1;
    logic             hit_ex1;
    logic             hit_ex2;
    logic             stall;
    logic [1:0]       next_fwd_sel;
    logic             ex1_bubble;
    logic [1:0]       ex1_fwd_sel;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] fwd_cnt;

    always_comb begin
        id_entry = '0;
        if (bus.id_valid) begin
            unique case (bus.id_opcode)
                OP_ADD1: begin
                    id_entry.writer = 1'b1;
                    id_entry.late   = 1'b1;
                    id_entry.rd     = bus.id_rd;
                end
                OP_ADD4, OP_SUB3, OP_MOV: begin
                    id_entry.writer = 1'b1;
                    id_entry.late   = 1'b0;
                    id_entry.rd     = bus.id_rd;
                end
                default: id_entry = '0;
            endcase
        end
    end

    // Every non-NOP opcode is also a writer, so id_entry.writer doubles as "real instruction".
    always_comb begin
        hit_ex1      = id_entry.writer && sb_ex1.writer && (sb_ex1.rd == bus.id_rs);
        hit_ex2      = id_entry.writer && sb_ex2.writer && (sb_ex2.rd == bus.id_rs);
        stall        = hit_ex1 && sb_ex1.late;
        next_fwd_sel = SEL_RF;
        if (stall) begin
            next_fwd_sel = SEL_RF;
        end else if (hit_ex1) begin
            next_fwd_sel = SEL_EX2;
        end else if (hit_ex2) begin
            next_fwd_sel = SEL_WB;
        end
        next_ex1 = stall ? ex1_entry_t'('0) : id_entry;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sb_ex1      <= '0;
            sb_ex2      <= '0;
            sb_wb       <= '0;
            ex1_bubble  <= 1'b0;
            ex1_fwd_sel <= SEL_RF;
        end else begin
            sb_ex1      <= next_ex1;
            sb_ex2      <= '{writer: sb_ex1.writer, rd: sb_ex1.rd};
            sb_wb       <= sb_ex2;
            ex1_bubble  <= stall;
            ex1_fwd_sel <= next_fwd_sel;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if ((next_fwd_sel != SEL_RF) && (fwd_cnt != '1)) begin
                fwd_cnt <= fwd_cnt + CNT_ONE;
            end
        end
    end

    assign bus.stall       = stall;
    assign bus.pc_we       = ~stall;
    assign bus.ifid_we     = ~stall;
    assign bus.ex1_bubble  = ex1_bubble;
    assign bus.ex1_fwd_sel = ex1_fwd_sel;
    assign bus.wb_wen      = sb_wb.writer;
    assign bus.wb_rd       = sb_wb.rd;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.fwd_cnt     = fwd_cnt;
endmodule

// File: tb/tb_ee457_p3_hazard_ctrl.sv
// tb/tb_ee457_p3_hazard_ctrl.sv - scoreboard bench for the P3 hazard/forwarding controller
module tb_ee457_p3_hazard_ctrl;
    localparam int CNT_W = 3;

    logic clk;
    logic rstb;
    int   n_tests;
    int   n_fail;

    ee457_p3_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    ee457_p3_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic       v;
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] rs;
        logic       st;
        logic       bub;
        logic [1:0] fwd;
        logic       wen;
        logic [3:0] wbrd;
        int         sc;
        int         fc;
    } row_t;

    row_t vecs[$];
    row_t expq[$];

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] rs, input logic st, input logic bub,
                       input logic [1:0] fwd, input logic wen, input logic [3:0] wbrd,
                       input int sc, input int fc);
        row_t r;
        r.idx = vecs.size() + 1;
        r.v = v; r.op = op; r.rd = rd; r.rs = rs;
        r.st = st; r.bub = bub; r.fwd = fwd; r.wen = wen; r.wbrd = wbrd;
        r.sc = sc; r.fc = fc;
        vecs.push_back(r);
    endtask

    task automatic nop(input logic wen, input logic [3:0] wbrd, input int sc, input int fc);
        add(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00, wen, wbrd, sc, fc);
    endtask

    // Monitor: pops one expected row per cycle; combinational checks mid-low-phase, registered after the edge.
    initial begin
        row_t e;
        forever begin
            @(negedge clk);
            #3;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("stall", e.idx, int'(bus.stall), int'(e.st));
                chk("pc_we", e.idx, int'(bus.pc_we), int'(!e.st));
                chk("ifid_we", e.idx, int'(bus.ifid_we), int'(!e.st));
                @(posedge clk);
                #1;
                chk("ex1_bubble", e.idx, int'(bus.ex1_bubble), int'(e.bub));
                chk("ex1_fwd_sel", e.idx, int'(bus.ex1_fwd_sel), int'(e.fwd));
                chk("wb_wen", e.idx, int'(bus.wb_wen), int'(e.wen));
                if (e.wen) chk("wb_rd", e.idx, int'(bus.wb_rd), int'(e.wbrd));
                chk("stall_cnt", e.idx, int'(bus.stall_cnt), e.sc);
                chk("fwd_cnt", e.idx, int'(bus.fwd_cnt), e.fc);
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstb = 1'b0;
        bus.id_valid = 1'b0; bus.id_opcode = 4'h0; bus.id_rd = 4'h0; bus.id_rs = 4'h0;

        // Fields: valid op rd rs | stall bubble fwd wen wb_rd stall_cnt fwd_cnt (fwd_cnt saturates at 7)
        add(1, 4'h4, 4'h1, 4'h2, 0, 0, 2'b00, 0, 4'h0, 0, 0);
        add(1, 4'h1, 4'h2, 4'h1, 0, 0, 2'b01, 0, 4'h0, 0, 1);
        nop(1, 4'h1, 0, 1);
        nop(1, 4'h2, 0, 1);
        add(1, 4'h1, 4'h1, 4'h2, 0, 0, 2'b00, 0, 4'h0, 0, 1);
        add(1, 4'h1, 4'h2, 4'h1, 1, 1, 2'b00, 0, 4'h0, 1, 1);
        add(1, 4'h1, 4'h2, 4'h1, 0, 0, 2'b10, 1, 4'h1, 1, 2);
        add(1, 4'h1, 4'hA, 4'h1, 0, 0, 2'b00, 0, 4'h0, 1, 2);
        nop(1, 4'h2, 1, 2);
        nop(1, 4'hA, 1, 2);
        add(1, 4'h4, 4'h1, 4'h2, 0, 0, 2'b00, 0, 4'h0, 1, 2);
        add(1, 4'h4, 4'h1, 4'h2, 0, 0, 2'b00, 0, 4'h0, 1, 2);
        add(1, 4'h1, 4'h4, 4'h1, 0, 0, 2'b01, 1, 4'h1, 1, 3);
        nop(1, 4'h1, 1, 3);
        nop(1, 4'h4, 1, 3);
        add(1, 4'h0, 4'h8, 4'h0, 0, 0, 2'b00, 0, 4'h0, 1, 3);
        add(1, 4'h4, 4'h8, 4'h8, 0, 0, 2'b00, 0, 4'h0, 1, 3);
        nop(0, 4'h0, 1, 3);
        nop(1, 4'h8, 1, 3);
        add(1, 4'h1, 4'h6, 4'h6, 0, 0, 2'b00, 0, 4'h0, 1, 3);
        add(1, 4'h1, 4'h6, 4'h6, 1, 1, 2'b00, 0, 4'h0, 2, 3);
        add(1, 4'h1, 4'h6, 4'h6, 0, 0, 2'b10, 1, 4'h6, 2, 4);
        add(1, 4'h1, 4'h6, 4'h6, 1, 1, 2'b00, 0, 4'h0, 3, 4);
        add(1, 4'h1, 4'h6, 4'h6, 0, 0, 2'b10, 1, 4'h6, 3, 5);
        add(1, 4'h8, 4'h9, 4'h6, 1, 1, 2'b00, 0, 4'h0, 4, 5);
        add(1, 4'h8, 4'h9, 4'h6, 0, 0, 2'b10, 1, 4'h6, 4, 6);
        add(1, 4'h4, 4'h9, 4'h9, 0, 0, 2'b01, 0, 4'h0, 4, 7);
        nop(1, 4'h9, 4, 7);
        nop(1, 4'h9, 4, 7);
        add(0, 4'h1, 4'h5, 4'h5, 0, 0, 2'b00, 0, 4'h0, 4, 7);
        add(1, 4'h1, 4'h3, 4'h5, 0, 0, 2'b00, 0, 4'h0, 4, 7);
        nop(0, 4'h0, 4, 7);
        nop(1, 4'h3, 4, 7);
        add(1, 4'h2, 4'h7, 4'h0, 0, 0, 2'b00, 0, 4'h0, 4, 7);
        add(1, 4'h3, 4'h7, 4'h7, 0, 0, 2'b00, 0, 4'h0, 4, 7);
        add(1, 4'h8, 4'hB, 4'h7, 0, 0, 2'b10, 1, 4'h7, 4, 7);
        nop(0, 4'h0, 4, 7);
        nop(1, 4'hB, 4, 7);

        #2;
        chk("rst_stall", 0, int'(bus.stall), 0);
        chk("rst_pc_we", 0, int'(bus.pc_we), 1);
        chk("rst_bubble", 0, int'(bus.ex1_bubble), 0);
        chk("rst_fwd_sel", 0, int'(bus.ex1_fwd_sel), 0);
        chk("rst_wb_wen", 0, int'(bus.wb_wen), 0);
        chk("rst_wb_rd", 0, int'(bus.wb_rd), 0);
        chk("rst_stall_cnt", 0, int'(bus.stall_cnt), 0);
        chk("rst_fwd_cnt", 0, int'(bus.fwd_cnt), 0);
        @(negedge clk);
        rstb = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.id_valid  = vecs[i].v;
            bus.id_opcode = vecs[i].op;
            bus.id_rd     = vecs[i].rd;
            bus.id_rs     = vecs[i].rs;
            expq.push_back(vecs[i]);
        end

        for (int i = 0; i < 200 && expq.size() != 0; i++) @(posedge clk);
        chk("drain_timeout", 0, expq.size(), 0);
        @(posedge clk);
        #3;

        // Reset while a stall is active must clear everything without a clock edge.
        @(negedge clk);
        bus.id_valid = 1'b1; bus.id_opcode = 4'h1; bus.id_rd = 4'h1; bus.id_rs = 4'h1;
        @(negedge clk);
        bus.id_rd = 4'h2;
        #2;
        chk("pre_rst_stall", 99, int'(bus.stall), 1);
        rstb = 1'b0;
        #1;
        chk("mid_rst_stall", 99, int'(bus.stall), 0);
        chk("mid_rst_ifid_we", 99, int'(bus.ifid_we), 1);
        chk("mid_rst_bubble", 99, int'(bus.ex1_bubble), 0);
        chk("mid_rst_fwd_sel", 99, int'(bus.ex1_fwd_sel), 0);
        chk("mid_rst_wb_wen", 99, int'(bus.wb_wen), 0);
        chk("mid_rst_stall_cnt", 99, int'(bus.stall_cnt), 0);
        chk("mid_rst_fwd_cnt", 99, int'(bus.fwd_cnt), 0);
        @(negedge clk);
        rstb = 1'b1;
        #1;
        chk("post_rst_stall", 99, int'(bus.stall), 0);
        @(posedge clk);
        #1;
        chk("post_rst_bubble", 99, int'(bus.ex1_bubble), 0);
        chk("post_rst_fwd_sel", 99, int'(bus.ex1_fwd_sel), 0);
        chk("post_rst_stall_cnt", 99, int'(bus.stall_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ee457_p3_hazard_ctrl.md
# ee457_p3_hazard_ctrl

Hazard and forwarding controller for the 5-stage lab7 P3 pipeline (IF, ID, EX1, EX2, WB) that executes NOP, ADD1, ADD4, SUB3 and MOV. The block sits beside the ID stage and keeps its own 3-entry scoreboard of the instructions in EX1, EX2 and WB. It issues the one-cycle ADD1 load-use stall, inserts the bubble, and drives registered operand-forwarding selects into EX1. It also drives the WB write enable and saturating stall and forward performance counters.

## Interface
- CNT_W, 16, width of the performance counters
- CLK  in  1  pipeline clock; all state updates on the rising edge
- RSTB  in  1  asynchronous, active-low reset
- ID_VALID  in  1  ID holds a real instruction (0 means treat as NOP)
- ID_OPCODE  in  4  instruction bits [31:28]
- ID_RD  in  4  destination register, instruction bits [7:4]
- ID_RS  in  4  source register, instruction bits [3:0]
- STALL  out  1  combinational; 1 means hold PC and IF/ID and inject a bubble into EX1
- PC_WE  out  1  combinational, equal to ~STALL
- IFID_WE  out  1  combinational, equal to ~STALL
- EX1_BUBBLE  out  1  registered; the EX1 instruction is a bubble (datapath substitutes 32'h0FFFFF00)
- EX1_FWD_SEL  out  2  registered operand select for EX1
  - 00: register file (with internal write-before-read)
  - 01: EX2 result
  - 10: WB result
- WB_WEN  out  1  registered; the WB instruction writes the register file
- WB_RD  out  4  registered destination of the WB instruction
- STALL_CNT  out  CNT_W  number of stall cycles, saturating
- FWD_CNT  out  CNT_W  number of forwarded (non-00) selects issued, saturating

## Operation
- Opcode decode:
  - ADD1 = 0001, ADD4 = 0010, SUB3 = 0100, MOV = 1000.
  - Every other code, and any instruction with ID_VALID = 0, is a NOP.
  - A NOP never writes and never forwards, whatever its RD field holds.
- Writers are ADD1, ADD4, SUB3 and MOV. The writer class sets when a result is ready:
  - Late writer (ADD1): result is ready at the end of EX2.
  - Early writers (ADD4, SUB3, MOV): result is ready at the end of EX1. MOV's result is its forwarded operand.
- Scoreboard: one entry each for EX1, EX2 and WB. An entry holds {writer, late, rd}.
  - Each cycle the entries shift EX1 -> EX2 -> WB, and the old WB entry retires.
  - The new EX1 entry is the decoded ID instruction, or a NOP bubble when STALL = 1.
- Hazard check for the ID instruction, for every opcode except NOP:
  - sEX1 = the EX1 entry is a writer and its rd equals ID_RS.
  - sEX2 = the same test against the EX2 entry.
- STALL = sEX1 and the EX1 entry is late.
- Next EX1_FWD_SEL, evaluated in priority order (nearest producer wins):
  - STALL: 00. This is a bubble; the held instruction is re-evaluated next cycle.
  - else sEX1: 01. The producer will be in EX2 next cycle.
  - else sEX2: 10. The producer will be in WB next cycle.
  - else: 00. A producer currently in WB is covered by the register-file bypass.
- FWD_SEL is always 00 for NOP or bubble.
- A STALL can never last more than one consecutive cycle. After the bubble, the late producer sits in EX2 and the held instruction gets 10.
- Counters: STALL_CNT increments on each STALL cycle. FWD_CNT increments on each cycle the next EX1_FWD_SEL is non-00. Both hold at all-ones.

## Timing
- Reset (RSTB = 0, asynchronous):
  - All scoreboard entries become NOP.
  - EX1_BUBBLE = 0, EX1_FWD_SEL = 00, WB_WEN = 0, WB_RD = 0, both counters = 0.
  - With the scoreboard empty, STALL = 0 and PC_WE = IFID_WE = 1.
- Reset asserted mid-stall clears everything immediately. After release, no stale stall or forward is issued.
- STALL, PC_WE and IFID_WE are same-cycle combinational functions of the ID inputs and the scoreboard.
- All other outputs change only on the CLK rising edge and describe the instruction that has just entered the corresponding stage.
- The decision latency from ID to its EX1 select is exactly 1 cycle.
- WB_WEN and WB_RD describe the WB instruction. This gives a 3-cycle latency from ID to WB_WEN.

## Test plan
- SUB3 $1,$2 then ADD1 $2,$1 -> no stall; at ADD1's EX1 cycle EX1_FWD_SEL = 01; FWD_CNT = 1.
- ADD1 $1,$2 then ADD1 $2,$1 then ADD1 $A,$1:
  - STALL = 1 for exactly one cycle while the second ADD1 is in ID; EX1_BUBBLE = 1 next cycle.
  - The second ADD1 then gets 10.
  - The third ADD1 gets 00 (register-file bypass).
  - STALL_CNT = 1.
- SUB3 $1,$2; SUB3 $1,$2; ADD1 $4,$1 -> priority: ADD1 gets 01 (nearest), not 10.
- NOP (RD = $8) followed by SUB3 $8,$8 -> EX1_FWD_SEL = 00, no stall, WB_WEN = 0 when the NOP reaches WB.
- ADD1 $6,$6 ×3 then MOV $9,$6 then SUB3 $9,$9:
  - Each dependent ADD1 and the MOV take one stall; STALL_CNT = 3.
  - SUB3 gets 01 from the MOV with no stall.
- Assert RSTB low while STALL = 1 -> all outputs reach reset values without a clock edge, and STALL = 0 after release.
